mypc_program_sequencer: RTL and testbench
=========================================

Name: mypc_program_sequencer

Overview:
Instruction-issuing front end for the 4-bit computer. Holds a loadable 16-word program and issues one instruction per clock as {pc_instr, A, B} to the computer's instruction/data inputs. Resolves control flow itself: JZ using the computer's zf output, CALL/RET on an internal return stack, and HLT.

Parameters:
PROG_DEPTH, 16, program words; fetch pointer width is log2(PROG_DEPTH) = 4.
RSTACK_DEPTH, 4, return-stack entries.
BUBBLE_OP, 15, opcode driven whenever issue_valid=0.

Ports:
mypc_clock  in  1  single clock, rising edge.
mypc_reset_n  in  1  reset, asynchronous, active-low.
load_en  in  1  program write strobe; honoured only in IDLE or HALT.
load_addr  in  4  program word address.
load_data  in  12  program word {opcode[11:8], A[7:4], B[3:0]}.
start  in  1  begin execution at word 0; honoured only in IDLE or HALT.
zf_in  in  1  zero flag from the computer.
pc_instr  out  4  issued opcode.
A_out  out  4  issued A operand.
B_out  out  4  issued B operand.
issue_valid  out  1  current outputs are a real instruction.
fetch_ptr  out  4  address of the next word to issue.
running  out  1  state is RUN or BUBBLE.
halted  out  1  state is HALT.
stack_err  out  1  return-stack overflow or underflow; sticky until start.

Behaviour:
- Reset (asynchronous, active-low) puts the block in IDLE with these values:
  - pc_instr = BUBBLE_OP; A_out = 0; B_out = 0.
  - issue_valid, fetch_ptr, running, halted, stack_err = 0.
  - Return-stack depth = 0. Program memory is not reset.
  - Reset asserted mid-RUN aborts immediately; no further issue.
- All outputs are registered. The computer executes an issued word at the edge after it appears.
- States: IDLE, RUN, BUBBLE, HALT.
- IDLE / HALT:
  - load_en=1 writes mem[load_addr] = load_data.
  - If load_en=1 and start=1 in the same cycle, the write happens and start is ignored.
  - start=1 with load_en=0 goes to RUN, sets fetch_ptr=0, clears depth and stack_err.
  - Outputs: BUBBLE_OP, A_out=0, B_out=0, issue_valid=0.
- RUN: each cycle registers {pc_instr, A_out, B_out} = mem[fetch_ptr] and sets issue_valid=1. The issued opcode decides the next state:
  - 0-9, 11, 12: fetch_ptr = fetch_ptr+1, wrapping 15 to 0; stay in RUN.
  - 10 (JZ), 13 (CALL), 14 (RET): go to BUBBLE and latch the opcode, target = A field, and return address = fetch_ptr+1 (wrapping).
  - 15 (HLT): issued once (issue_valid=1), then HALT; fetch_ptr unchanged.
  - load_en is ignored in RUN and BUBBLE.
- BUBBLE: exactly one cycle with BUBBLE_OP, A_out=0, B_out=0, issue_valid=0. The computer may pulse stop_flag here; that pulse is not a halt. Resolution at the edge ending the BUBBLE cycle:
  - JZ: zf_in is sampled at this edge; it reflects the instruction issued immediately before JZ. zf_in=1 sets fetch_ptr = target, otherwise return address. Then RUN.
  - CALL: if depth < RSTACK_DEPTH, push return address, fetch_ptr = target, RUN. If full: stack_err=1, HALT, fetch_ptr unchanged.
  - RET: if depth > 0, pop into fetch_ptr, RUN. If empty: stack_err=1, HALT.
- running = (state is RUN or BUBBLE); halted = (state is HALT); both registered with the state.
- Branch cost: JZ, CALL and RET each take 2 cycles; every other opcode takes 1.

Test Plan:
- Load mem[0..2] = {0,3,4}, {7,5,6}, {15,0,0}; pulse start. Expect issue_valid=1 for 3 consecutive cycles with pc_instr 0, 7, 15, A 3, 5, 0; then halted=1, fetch_ptr=2, pc_instr=15, issue_valid=0.
- mem[0] = {1,4,4}, mem[1] = {10,9,0}, zf_in driven 1 during the bubble. Expect issue order 1, 10, bubble, then mem[9]. Repeat with zf_in=0: mem[2] follows the bubble.
- CALL/RET: mem[0] = {13,5,0}, mem[5] = {14,0,0}, mem[1] = {15,0,0}. Expect issue order 0, bubble, 5, bubble, 1, then HALT with stack_err=0.
- Overflow: mem[0] = {13,0,0} calls itself. After 4 successful calls, the 5th bubble sets stack_err=1 and halted=1. A following start clears stack_err and reissues from word 0.
- Assert load_en with new data to address 0 while in RUN: the write is ignored and the old word is reissued after the program returns to 0. In HALT the same write succeeds.
- Assert mypc_reset_n=0 mid-RUN, asynchronously between edges. Outputs go to reset values immediately (pc_instr=15, issue_valid=0, fetch_ptr=0). After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/mypc_program_sequencer.sv
// rtl/mypc_program_sequencer.sv - program store and issue sequencer for the 4-bit computer
// Issues one {opcode, A, B} word per clock and resolves JZ, CALL/RET and HLT locally.
module mypc_program_sequencer #(
    parameter int PROG_DEPTH   = 16,
    parameter int RSTACK_DEPTH = 4,
    parameter int BUBBLE_OP    = 15
) (
    input  logic                          mypc_clock,
    input  logic                          mypc_reset_n,
    input  logic                          load_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
    input  logic [11:0]                   load_data,
    input  logic                          start,
    input  logic                          zf_in,
    output logic [3:0]                    pc_instr,
    output logic [3:0]                    A_out,
    output logic [3:0]                    B_out,
    output logic                          issue_valid,
    output logic [$clog2(PROG_DEPTH)-1:0] fetch_ptr,
    output logic                          running,
    output logic                          halted,
    output logic                          stack_err
);

    localparam int PW = $clog2(PROG_DEPTH);
    localparam int DW = $clog2(RSTACK_DEPTH + 1);

    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd13;
    localparam logic [3:0] OP_RET  = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [11:0]   prog_mem [PROG_DEPTH];
    logic [PW-1:0] rstack   [RSTACK_DEPTH];
    logic [DW-1:0] depth, depth_nxt, depth_dec;

    logic [3:0]    br_op;
    logic [PW-1:0] br_target, br_ret;

    logic [11:0]   cur_word;
    logic [3:0]    cur_op;
    logic [PW-1:0] ptr_inc, ptr_nxt, pop_val;
    logic          mem_we, latch_br, push, err_nxt;

    logic [3:0]    pc_nxt, a_nxt, b_nxt;
    logic          valid_nxt, running_nxt, halted_nxt;

    assign cur_word  = prog_mem[fetch_ptr];
    assign cur_op    = cur_word[11:8];
    assign ptr_inc   = fetch_ptr + PW'(1);
    assign depth_dec = depth - DW'(1);
    assign mem_we    = load_en && ((state == S_IDLE) || (state == S_HALT));

    // Program memory has no reset so a loaded program survives a reset pulse.
    always_ff @(posedge mypc_clock) begin
        if (mem_we) begin
            prog_mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        pop_val = '0;
        for (int i = 0; i < RSTACK_DEPTH; i++) begin
            if (depth_dec == DW'(i)) begin
                pop_val = rstack[i];
            end
        end
    end

    always_ff @(posedge mypc_clock or negedge mypc_reset_n) begin
        if (!mypc_reset_n) begin
            state       <= S_IDLE;
            fetch_ptr   <= '0;
            depth       <= '0;
            stack_err   <= 1'b0;
            pc_instr    <= 4'(BUBBLE_OP);
            A_out       <= '0;
            B_out       <= '0;
            issue_valid <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            br_op       <= '0;
            br_target   <= '0;
            br_ret      <= '0;
            for (int i = 0; i < RSTACK_DEPTH; i++) begin
                rstack[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            fetch_ptr   <= ptr_nxt;
            depth       <= depth_nxt;
            stack_err   <= err_nxt;
            pc_instr    <= pc_nxt;
            A_out       <= a_nxt;
            B_out       <= b_nxt;
            issue_valid <= valid_nxt;
            running     <= running_nxt;
            halted      <= halted_nxt;
            if (latch_br) begin
                br_op     <= cur_op;
                br_target <= PW'(cur_word[7:4]);
                br_ret    <= ptr_inc;
            end
            for (int i = 0; i < RSTACK_DEPTH; i++) begin
                if (push && (depth == DW'(i))) begin
                    rstack[i] <= br_ret;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = fetch_ptr;
        depth_nxt = depth;
        err_nxt   = stack_err;
        latch_br  = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                // A write in the same cycle as start wins; start is dropped.
                if (start && !load_en) begin
                    state_nxt = S_RUN;
                    ptr_nxt   = '0;
                    depth_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                case (cur_op)
                    OP_JZ, OP_CALL, OP_RET: begin
                        state_nxt = S_BUBBLE;
                        latch_br  = 1'b1;
                    end
                    OP_HLT:  state_nxt = S_HALT;
                    default: ptr_nxt   = ptr_inc;
                endcase
            end
            S_BUBBLE: begin
                state_nxt = S_RUN;
                case (br_op)
                    OP_JZ: ptr_nxt = zf_in ? br_target : br_ret;
                    OP_CALL: begin
                        if (depth < DW'(RSTACK_DEPTH)) begin
                            push      = 1'b1;
                            depth_nxt = depth + DW'(1);
                            ptr_nxt   = br_target;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = S_HALT;
                        end
                    end
                    OP_RET: begin
                        if (depth != '0) begin
                            depth_nxt = depth_dec;
                            ptr_nxt   = pop_val;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = S_HALT;
                        end
                    end
                    default: ptr_nxt = br_ret;
                endcase
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The issued word depends on the current state; status flags follow the next state.
    always_comb begin
        pc_nxt    = 4'(BUBBLE_OP);
        a_nxt     = '0;
        b_nxt     = '0;
        valid_nxt = 1'b0;
        if (state == S_RUN) begin
            pc_nxt    = cur_word[11:8];
            a_nxt     = cur_word[7:4];
            b_nxt     = cur_word[3:0];
            valid_nxt = 1'b1;
        end
        running_nxt = (state_nxt == S_RUN) || (state_nxt == S_BUBBLE);
        halted_nxt  = (state_nxt == S_HALT);
    end

endmodule

// File: tb/tb_mypc_program_sequencer.sv
// tb/tb_mypc_program_sequencer.sv - directed vector bench for mypc_program_sequencer
module tb_mypc_program_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [11:0] load_data = '0;
    logic        start = 1'b0;
    logic        zf_in = 1'b0;
    logic [3:0]  pc_instr, a_out, b_out, fetch_ptr;
    logic        issue_valid, running, halted, stack_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        le;
        logic [3:0]  la;
        logic [11:0] ld;
        logic        st;
        logic        zf;
        logic [3:0]  pc;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        v;
        logic [3:0]  fp;
        logic        run;
        logic        hlt;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_part1;

    mypc_program_sequencer dut (
        .mypc_clock   (clk),
        .mypc_reset_n (rst_n),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .zf_in        (zf_in),
        .pc_instr     (pc_instr),
        .A_out        (a_out),
        .B_out        (b_out),
        .issue_valid  (issue_valid),
        .fetch_ptr    (fetch_ptr),
        .running      (running),
        .halted       (halted),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int le, input int la, input int ld, input int st, input int zf,
                                input int pc, input int a, input int b, input int v, input int fp,
                                input int run, input int hlt, input int err);
        vec_t r;
        r.le = 1'(le);  r.la = 4'(la);  r.ld = 12'(ld); r.st = 1'(st);   r.zf = 1'(zf);
        r.pc = 4'(pc);  r.a = 4'(a);    r.b = 4'(b);    r.v = 1'(v);     r.fp = 4'(fp);
        r.run = 1'(run); r.hlt = 1'(hlt); r.err = 1'(err);
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, idx, got, want);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t e);
        chk("pc_instr", idx, pc_instr, e.pc);
        chk("A_out", idx, a_out, e.a);
        chk("B_out", idx, b_out, e.b);
        chk("issue_valid", idx, 4'(issue_valid), 4'(e.v));
        chk("fetch_ptr", idx, fetch_ptr, e.fp);
        chk("running", idx, 4'(running), 4'(e.run));
        chk("halted", idx, 4'(halted), 4'(e.hlt));
        chk("stack_err", idx, 4'(stack_err), 4'(e.err));
    endtask

    task automatic apply(input int idx);
        load_en   = vecs[idx].le;
        load_addr = vecs[idx].la;
        load_data = vecs[idx].ld;
        start     = vecs[idx].st;
        zf_in     = vecs[idx].zf;
        @(posedge clk);
        #1;
        chk_all(idx, vecs[idx]);
    endtask

    initial begin
        // straight-line program ending in HLT
        vecs.push_back(mk(1, 0, 'h034, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h756, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 'hF00, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0,  0, 3, 4, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0,  7, 5, 6, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        // JZ taken: zf sampled at the edge ending the bubble
        vecs.push_back(mk(1, 0, 'h144, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 1, 'hA90, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 9, 'hF12, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0,  1, 4, 4, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 10, 9, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 15, 0, 0, 0, 9, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 1, 2, 1, 9, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 9, 0, 1, 0));
        // JZ not taken; zf high only one cycle early must be ignored
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0,  1, 4, 4, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 10, 9, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        // CALL then RET
        vecs.push_back(mk(1, 0, 'hD50, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 5, 'hE00, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 1, 'hF00, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 13, 5, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 14, 0, 0, 1, 5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 1, 0, 1, 0));
        // recursive CALL overflows on the fifth push
        vecs.push_back(mk(1, 0, 'hD00, 0, 0, 15, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 13, 0, 0, 1, 0, 1, 0, 0));
            vecs.push_back(mk(0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0,     0, 0, 13, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 13, 0, 0, 1, 0, 1, 0, 0));
        n_part1 = vecs.size();
        // after reset: writes during RUN are dropped, writes in HALT land
        vecs.push_back(mk(1, 0, 'h211, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'hA00, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 'hF00, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 1, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 'h555, 0, 1,  2, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 'h555, 0, 1, 10, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 'h555, 0, 1, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 'h555, 0, 1,  2, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 10, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 'hF77, 0, 0, 15, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 15, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 7, 7, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 15, 0, 0, 0, 0, 0, 1, 0));
        // load and start together: write wins, block stays halted
        vecs.push_back(mk(1, 5, 'h123, 1, 0, 15, 0, 0, 0, 0, 0, 1, 0));

        #12;
        chk_all(-1, mk(0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n_part1; i++) apply(i);

        // asynchronous reset between edges while a CALL bubble is pending
        load_en = 1'b0;
        start   = 1'b0;
        zf_in   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(-2, mk(0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_all(-3 - k, mk(0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0));
        end

        for (int i = n_part1; i < vecs.size(); i++) apply(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
